// File: rtl/task_arb_pkg.sv
// Shared types and helpers for the task frame arbiter.
package task_arb_pkg;

    typedef enum logic [1:0] {
        s_IDLE,
        s_GRANT,
        s_RELEASE
    } task_arb_state_e;

    function automatic int task_arb_id_width(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/task_rr_pick.sv
// Rotating-priority encoder: first set request searching upward from ptr+1 with wrap.
module task_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    // Scan from the farthest offset back to the nearest so the nearest hit wins.
    always_comb begin
        int cand;
        found = 1'b0;
        idx   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = (int'(ptr) + off) % NUM_REQ;
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/task_frame_arbiter.sv
// Frame-level round-robin arbiter sharing one core among NUM_REQ loaders.
// Optional watchdog release is enabled by defining TASK_ARB_TIMEOUT_EN.
module task_frame_arbiter
    import task_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [NUM_REQ-1:0]                    i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]         i_data,
    input  logic [NUM_REQ-1:0]                    i_enb,
    input  logic                                  i_core_last,
    output logic [NUM_REQ-1:0]                    o_grant,
    output logic [task_arb_id_width(NUM_REQ)-1:0] o_grant_id,
    output logic [DATA_WIDTH-1:0]                 o_data,
    output logic                                  o_enb,
    output logic [NUM_REQ-1:0]                    o_output_last,
    output logic                                  o_busy,
    output logic                                  o_timeout
);

    localparam int ID_W = task_arb_id_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("task_frame_arbiter: unsupported parameter set");
    end

    task_arb_state_e      state;
    logic [ID_W-1:0]      ptr;
    logic                 pick_found;
    logic [ID_W-1:0]      pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic                 timeout_hit;
    logic                 release_now;

    task_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (i_req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign pick_onehot  = NUM_REQ'(1) << pick_idx;
    assign grant_onehot = NUM_REQ'(1) << o_grant_id;
    assign release_now  = (state == s_GRANT) && (i_core_last || timeout_hit);
    assign o_busy       = (state != s_IDLE);

`ifdef TASK_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] idle_cnt;
    logic             timeout_q;

    // Watchdog counts grant cycles without a granted beat; a real end-of-frame wins a tie.
    assign timeout_hit = (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !i_enb[o_grant_id];
    assign o_timeout   = timeout_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= release_now && !i_core_last;
            if (state != s_GRANT || i_enb[o_grant_id]) begin
                idle_cnt <= '0;
            end else if (!timeout_hit) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    // Main FSM; o_enb is only ever set while a grant is held.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= s_IDLE;
            ptr           <= ID_W'(NUM_REQ - 1);
            o_grant       <= '0;
            o_grant_id    <= '0;
            o_data        <= '0;
            o_enb         <= 1'b0;
            o_output_last <= '0;
        end else begin
            o_output_last <= '0;
            case (state)
                s_IDLE: begin
                    o_enb <= 1'b0;
                    if (pick_found) begin
                        o_grant    <= pick_onehot;
                        o_grant_id <= pick_idx;
                        state      <= s_GRANT;
                    end
                end
                s_GRANT: begin
                    if (release_now) begin
                        o_grant       <= '0;
                        o_data        <= '0;
                        o_enb         <= 1'b0;
                        o_output_last <= grant_onehot;
                        ptr           <= o_grant_id;
                        state         <= s_RELEASE;
                    end else begin
                        o_data <= i_data[o_grant_id*DATA_WIDTH +: DATA_WIDTH];
                        o_enb  <= i_enb[o_grant_id];
                    end
                end
                s_RELEASE: begin
                    o_enb <= 1'b0;
                    state <= s_IDLE;
                end
                default: begin
                    o_grant <= '0;
                    o_enb   <= 1'b0;
                    state   <= s_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_task_frame_arbiter.sv
// Self-checking bench for task_frame_arbiter with a transaction-level round-robin model.
// Define TASK_ARB_TIMEOUT_EN to also exercise the watchdog release.
module tb_task_frame_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 16;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req;
    logic [N*W-1:0] i_data;
    logic [N-1:0]   i_enb;
    logic           i_core_last;
    logic [N-1:0]   o_grant;
    logic [1:0]     o_grant_id;
    logic [W-1:0]   o_data;
    logic           o_enb;
    logic [N-1:0]   o_output_last;
    logic           o_busy;
    logic           o_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    task_frame_arbiter #(
        .NUM_REQ        (N),
        .DATA_WIDTH     (W),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req         (i_req),
        .i_data        (i_data),
        .i_enb         (i_enb),
        .i_core_last   (i_core_last),
        .o_grant       (o_grant),
        .o_grant_id    (o_grant_id),
        .o_data        (o_data),
        .o_enb         (o_enb),
        .o_output_last (o_output_last),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Round-robin rule: first requesting channel after the last served one, wrapping.
    function automatic int rr_expect(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++) begin
            if (req[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_req       = '0;
        i_data      = '0;
        i_enb       = '0;
        i_core_last = 1'b0;
        i_rst       = 1'b1;
        step();
        step();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({o_grant, o_grant_id, o_data, o_enb, o_output_last, o_busy, o_timeout} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got grant=%b id=%0d data=%h enb=%b last=%b busy=%b to=%b, expected all 0",
                     o_grant, o_grant_id, o_data, o_enb, o_output_last, o_busy, o_timeout);
        end
    endtask

    task automatic test_single();
        do_reset();
        i_req = 4'b0100;
        step();
        n_tests++;
        if (o_grant !== 4'b0100 || o_grant_id !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL single_grant: got grant=%b id=%0d, expected 0100 id=2", o_grant, o_grant_id);
        end
        i_data[2*W +: W] = 8'hA5;
        i_enb = 4'b0100;
        step();
        n_tests++;
        if (o_data !== 8'hA5 || o_enb !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_data: got data=%h enb=%b, expected a5 1", o_data, o_enb);
        end
        i_enb = '0;
        i_core_last = 1'b1;
        step();
        n_tests++;
        if (o_output_last !== 4'b0100 || o_grant !== '0 || o_busy !== 1'b1 || o_enb !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_last: got last=%b grant=%b busy=%b enb=%b, expected 0100 0000 1 0",
                     o_output_last, o_grant, o_busy, o_enb);
        end
        i_core_last = 1'b0;
        i_req = '0;
        step();
        n_tests++;
        if (o_output_last !== '0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_idle: got last=%b busy=%b, expected 0000 0", o_output_last, o_busy);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        i_req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            step();
            n_tests++;
            if (o_grant !== onehot(f % N) || o_grant_id !== 2'(f % N)) begin
                n_fail++;
                $display("[TB] FAIL fair_order[%0d]: got grant=%b id=%0d, expected id=%0d", f, o_grant, o_grant_id, f % N);
            end
            repeat (9) step();
            i_core_last = 1'b1;
            step();
            i_core_last = 1'b0;
            n_tests++;
            if (o_output_last !== onehot(f % N)) begin
                n_fail++;
                $display("[TB] FAIL fair_last[%0d]: got %b, expected %b", f, o_output_last, onehot(f % N));
            end
            step();
            n_tests++;
            if (o_grant !== '0) begin
                n_fail++;
                $display("[TB] FAIL fair_gap[%0d]: got grant=%b, expected 0000", f, o_grant);
            end
        end
    endtask

    task automatic test_isolation();
        logic [W-1:0] d1;
        logic         e1;
        do_reset();
        i_req = 4'b0010;
        step();
        n_tests++;
        if (o_grant !== 4'b0010) begin
            n_fail++;
            $display("[TB] FAIL iso_grant: got %b, expected 0010", o_grant);
        end
        for (int c = 0; c < 8; c++) begin
            d1 = W'($urandom) & 8'h7F;
            e1 = 1'($urandom);
            i_data = $urandom;
            i_data[1*W +: W] = d1;
            i_data[3*W +: W] = 8'hFF;
            i_enb = {1'b1, 1'($urandom), e1, 1'($urandom)};
            step();
            n_tests++;
            if (o_data !== d1 || o_enb !== e1) begin
                n_fail++;
                $display("[TB] FAIL iso_beat[%0d]: got data=%h enb=%b, expected %h %b", c, o_data, o_enb, d1, e1);
            end
        end
        i_enb = '0;
        i_core_last = 1'b1;
        step();
        i_core_last = 1'b0;
        n_tests++;
        if (o_output_last !== 4'b0010) begin
            n_fail++;
            $display("[TB] FAIL iso_last: got %b, expected 0010", o_output_last);
        end
    endtask

    task automatic test_spurious_last();
        do_reset();
        i_core_last = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            n_tests++;
            if (o_output_last !== '0 || o_busy !== 1'b0 || o_grant !== '0) begin
                n_fail++;
                $display("[TB] FAIL spurious_idle[%0d]: got last=%b busy=%b grant=%b, expected 0", c, o_output_last, o_busy, o_grant);
            end
        end
        i_core_last = 1'b0;
        i_req = 4'b1000;
        step();
        n_tests++;
        if (o_grant !== 4'b1000 || o_grant_id !== 2'd3 || o_output_last !== '0) begin
            n_fail++;
            $display("[TB] FAIL spurious_next: got grant=%b id=%0d last=%b, expected 1000 3 0000", o_grant, o_grant_id, o_output_last);
        end
        i_core_last = 1'b1;
        step();
        i_core_last = 1'b0;
        n_tests++;
        if (o_output_last !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL spurious_release: got %b, expected 1000", o_output_last);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        i_req = 4'b0100;
        step();
        i_data[2*W +: W] = 8'h5A;
        i_enb = 4'b0100;
        step();
        n_tests++;
        if (o_enb !== 1'b1 || o_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rstmid_pre: got enb=%b busy=%b, expected 1 1", o_enb, o_busy);
        end
        #2;
        i_rst = 1'b1;
        #1;
        n_tests++;
        if (o_grant !== '0 || o_enb !== 1'b0 || o_busy !== 1'b0 || o_output_last !== '0) begin
            n_fail++;
            $display("[TB] FAIL rstmid_async: got grant=%b enb=%b busy=%b last=%b, expected 0",
                     o_grant, o_enb, o_busy, o_output_last);
        end
        step();
        i_rst = 1'b0;
        i_enb = '0;
        i_req = 4'b0011;
        step();
        n_tests++;
        if (o_grant !== 4'b0001 || o_grant_id !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL rstmid_regrant: got grant=%b id=%0d, expected 0001 0", o_grant, o_grant_id);
        end
    endtask

    // Random frames: requests, beat data and spurious lasts all drawn at random.
    task automatic test_random();
        int           last;
        int           exp;
        int           len;
        logic [N-1:0] req;
        logic [W-1:0] exp_d;
        logic         exp_e;
        do_reset();
        last = N - 1;
        for (int f = 0; f < 30; f++) begin
            req = N'($urandom_range(1, (1 << N) - 1));
            exp = rr_expect(req, last);
            i_req = req;
            i_core_last = 1'b0;
            i_enb = '0;
            step();
            n_tests++;
            if (o_grant !== onehot(exp) || o_grant_id !== 2'(exp) || o_busy !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL rand_grant[%0d]: req=%b got grant=%b id=%0d busy=%b, expected id=%0d",
                         f, req, o_grant, o_grant_id, o_busy, exp);
            end
            len = $urandom_range(1, 10);
            for (int c = 0; c < len; c++) begin
                i_data = $urandom;
                i_enb  = N'($urandom);
                if ($urandom_range(0, 3) == 0) i_req = N'($urandom);
                exp_d = i_data[exp*W +: W];
                exp_e = i_enb[exp];
                step();
                n_tests++;
                if (o_data !== exp_d || o_enb !== exp_e || o_grant !== onehot(exp)) begin
                    n_fail++;
                    $display("[TB] FAIL rand_beat[%0d.%0d]: got data=%h enb=%b grant=%b, expected %h %b %b",
                             f, c, o_data, o_enb, o_grant, exp_d, exp_e, onehot(exp));
                end
            end
            i_data = $urandom;
            i_enb  = N'($urandom);
            i_core_last = 1'b1;
            step();
            n_tests++;
            if (o_output_last !== onehot(exp) || o_grant !== '0 || o_enb !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rand_last[%0d]: got last=%b grant=%b enb=%b, expected %b 0000 0",
                         f, o_output_last, o_grant, o_enb, onehot(exp));
            end
            i_core_last = 1'($urandom);
            i_req = N'($urandom);
            step();
            n_tests++;
            if (o_output_last !== '0 || o_grant !== '0 || o_busy !== 1'b0 || o_enb !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rand_gap[%0d]: got last=%b grant=%b busy=%b enb=%b, expected 0",
                         f, o_output_last, o_grant, o_busy, o_enb);
            end
            last = exp;
        end
        i_core_last = 1'b0;
        i_enb = '0;
    endtask

    task automatic test_timeout();
        logic exp_to;
        do_reset();
        i_req = 4'b0100;
        step();
`ifdef TASK_ARB_TIMEOUT_EN
        for (int k = 1; k <= T; k++) begin
            step();
            exp_to = (k == T);
            n_tests++;
            if (o_timeout !== exp_to) begin
                n_fail++;
                $display("[TB] FAIL timeout_pulse[%0d]: got %b, expected %b", k, o_timeout, exp_to);
            end
        end
        n_tests++;
        if (o_output_last !== 4'b0100 || o_grant !== '0) begin
            n_fail++;
            $display("[TB] FAIL timeout_release: got last=%b grant=%b, expected 0100 0000", o_output_last, o_grant);
        end
        i_req = 4'b1111;
        step();
        step();
        n_tests++;
        if (o_grant !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL timeout_next: got %b, expected 1000", o_grant);
        end
`else
        for (int k = 1; k <= T + 4; k++) begin
            step();
            exp_to = 1'b0;
            n_tests++;
            if (o_timeout !== exp_to || o_grant !== 4'b0100) begin
                n_fail++;
                $display("[TB] FAIL no_timeout[%0d]: got to=%b grant=%b, expected 0 0100", k, o_timeout, o_grant);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_isolation();
        test_spurious_last();
        test_reset_mid_grant();
        test_random();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
